snax_tcdm_bank_responder: RTL and testbench

//  Responder end of the SNAX TCDM request/response interface: a multi-port, word-interleaved banked

---
 rtl/snax_tcdm_bank_responder_if.sv | 28 ++
 rtl/snax_tcdm_bank_responder.sv | 134 +++++++++++++
 tb/tb_snax_tcdm_bank_responder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snax_tcdm_bank_responder_if.sv
// SNAX TCDM request/response bundle for a multi-port banked responder.
// Each per-port field is flattened, with port k in slice [k*W +: W].
interface snax_tcdm_bank_responder_if #(
  parameter int unsigned NumPorts  = 16,
  parameter int unsigned AddrWidth = 17,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [NumPorts-1:0]           q_valid;
  logic [NumPorts-1:0]           q_ready;
  logic [NumPorts*AddrWidth-1:0] q_addr;
  logic [NumPorts-1:0]           q_write;
  logic [NumPorts*DataWidth-1:0] q_data;
  logic [NumPorts*StrbWidth-1:0] q_strb;
  logic [NumPorts-1:0]           p_valid;
  logic [NumPorts*DataWidth-1:0] p_data;

  modport master (
    output q_valid, q_addr, q_write, q_data, q_strb,
    input  q_ready, p_valid, p_data
  );

  modport slave (
    input  q_valid, q_addr, q_write, q_data, q_strb,
    output q_ready, p_valid, p_data
  );
endinterface

// File: rtl/snax_tcdm_bank_responder.sv
// Word-interleaved banked scratchpad answering SNAX TCDM initiators.
// Per-bank round-robin arbitration; reads return one cycle after grant;
// writes are byte-masked and produce no response. Upper address bits alias.
module snax_tcdm_bank_responder #(
  parameter int unsigned NumPorts  = 16,
  parameter int unsigned NumBanks  = 32,
  parameter int unsigned BankDepth = 256,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 17
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  snax_tcdm_bank_responder_if.slave  tcdm,
  output logic [31:0]                conflict_cnt_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam int unsigned BankW     = $clog2(NumBanks);
  localparam int unsigned RowW      = $clog2(BankDepth);
  localparam int unsigned PortW     = $clog2(NumPorts);
  localparam int unsigned CntW      = $clog2(NumPorts + 1);

  logic [BankW-1:0]     port_bank  [NumPorts];
  logic [RowW-1:0]      port_row   [NumPorts];
  logic [DataWidth-1:0] port_wdata [NumPorts];
  logic [StrbWidth-1:0] port_strb  [NumPorts];
  logic                 unused_addr_bits;

  logic [PortW-1:0]     ptr_q    [NumBanks];
  logic [PortW-1:0]     bank_win [NumBanks];
  logic [NumBanks-1:0]  bank_gnt;
  logic [NumPorts-1:0]  gnt;

  logic [DataWidth-1:0] mem [NumBanks][BankDepth];

  logic [NumPorts-1:0]  p_valid_q;
  logic [DataWidth-1:0] p_data_q [NumPorts];
  logic [CntW-1:0]      stall_cnt;
  logic [32:0]          cnt_sum;
  logic [31:0]          cnt_q;

  // Split the flattened request bus into per-port bank/row/data/strobe fields.
  always_comb begin
    unused_addr_bits = 1'b0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      port_bank[k]  = tcdm.q_addr[k*AddrWidth+OffW +: BankW];
      port_row[k]   = tcdm.q_addr[k*AddrWidth+OffW+BankW +: RowW];
      port_wdata[k] = tcdm.q_data[k*DataWidth +: DataWidth];
      port_strb[k]  = tcdm.q_strb[k*StrbWidth +: StrbWidth];
      // Word offset and bits above the row index are ignored (aliasing).
      unused_addr_bits ^= ^tcdm.q_addr[k*AddrWidth +: AddrWidth];
    end
  end

  // Per bank: grant the first requester at or after the priority pointer.
  always_comb begin
    int unsigned k;
    gnt      = '0;
    bank_gnt = '0;
    k        = 0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      bank_win[b] = '0;
    end
    if (!rst_i) begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        for (int unsigned i = 0; i < NumPorts; i++) begin
          k = (32'(ptr_q[b]) + i) % NumPorts;
          if (!bank_gnt[b] && tcdm.q_valid[k] && (port_bank[k] == BankW'(b))) begin
            bank_gnt[b] = 1'b1;
            bank_win[b] = PortW'(k);
            gnt[k]      = 1'b1;
          end
        end
      end
    end
  end

  // Count requesting ports that were not granted this cycle.
  always_comb begin
    stall_cnt = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      stall_cnt += CntW'(tcdm.q_valid[k] & ~gnt[k]);
    end
    cnt_sum = {1'b0, cnt_q} + 33'(stall_cnt);
  end

  // Byte-masked writes from each bank's winner; storage itself is never reset.
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < NumBanks; b++) begin
      if (bank_gnt[b] && tcdm.q_write[bank_win[b]]) begin
        for (int unsigned j = 0; j < StrbWidth; j++) begin
          if (port_strb[bank_win[b]][j]) begin
            mem[b][port_row[bank_win[b]]][j*8 +: 8] <= port_wdata[bank_win[b]][j*8 +: 8];
          end
        end
      end
    end
  end

  // Pointers, read responses and the saturating conflict counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '{default: '0};
      p_valid_q <= '0;
      p_data_q  <= '{default: '0};
      cnt_q     <= '0;
    end else begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        if (bank_gnt[b]) begin
          ptr_q[b] <= (bank_win[b] == PortW'(NumPorts - 1)) ? '0 : bank_win[b] + 1'b1;
        end
      end
      for (int unsigned k = 0; k < NumPorts; k++) begin
        p_valid_q[k] <= gnt[k] & ~tcdm.q_write[k];
        if (gnt[k] && !tcdm.q_write[k]) begin
          p_data_q[k] <= mem[port_bank[k]][port_row[k]];
        end
      end
      cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end
  end

  // Drive the response side of the bundle.
  always_comb begin
    tcdm.q_ready = gnt;
    tcdm.p_valid = p_valid_q;
    tcdm.p_data  = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      tcdm.p_data[k*DataWidth +: DataWidth] = p_data_q[k];
    end
  end

  assign conflict_cnt_o = cnt_q;
endmodule

// File: tb/tb_snax_tcdm_bank_responder.sv
// Scoreboard bench for snax_tcdm_bank_responder: a driver issues requests and
// predicts grants, memory contents and counter from a word-level model; a
// monitor pops expected responses as the DUT presents them.
module tb_snax_tcdm_bank_responder;
  localparam int NP = 16;
  localparam int NB = 32;
  localparam int DW = 64;
  localparam int AW = 17;
  localparam int SW = DW / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_req;
  logic [31:0] conflict_cnt;

  always #5 clk = ~clk;

  snax_tcdm_bank_responder_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) tcdm ();

  snax_tcdm_bank_responder #(
    .NumPorts(NP), .NumBanks(NB), .BankDepth(256), .DataWidth(DW), .AddrWidth(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tcdm(tcdm), .conflict_cnt_o(conflict_cnt)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit mon_en = 1'b0;

  // Pending request per port; held until the model predicts a grant.
  bit          rv   [NP];
  int          ra   [NP];
  bit          rw   [NP];
  logic [DW-1:0] rdat [NP];
  logic [SW-1:0] rs   [NP];

  // Reference model: word store keyed by aliased word index, bank pointers, counter.
  logic [DW-1:0]   mem_m [int];
  int              ptr_m [NB];
  longint unsigned exp_cnt;

  typedef struct {
    int            cyc;
    bit            known;
    logic [DW-1:0] data;
  } exp_t;
  exp_t expq [NP][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bank_of(input int a);
    return (a / 8) % NB;
  endfunction

  function automatic int word_of(input int a);
    return (a % 65536) / 8;
  endfunction

  task automatic reset_model();
    for (int b = 0; b < NB; b++) ptr_m[b] = 0;
    for (int k = 0; k < NP; k++) begin
      expq[k].delete();
      rv[k] = 1'b0;
    end
    exp_cnt = 0;
  endtask

  task automatic req(input int k, input bit wr, input int addr,
                     input logic [DW-1:0] d, input logic [SW-1:0] s);
    rv[k] = 1'b1; rw[k] = wr; ra[k] = addr; rdat[k] = d; rs[k] = s;
  endtask

  // One clock cycle: drive at negedge, predict and check grants, update model.
  task automatic step();
    logic [NP-1:0] g;
    int best, bestd, d, stalls, w;
    exp_t e;
    logic [DW-1:0] word;
    @(negedge clk);
    rst = rst_req;
    for (int k = 0; k < NP; k++) begin
      tcdm.q_valid[k]            = rv[k];
      tcdm.q_write[k]            = rw[k];
      tcdm.q_addr[k*AW +: AW]    = AW'(ra[k]);
      tcdm.q_data[k*DW +: DW]    = rdat[k];
      tcdm.q_strb[k*SW +: SW]    = rs[k];
    end
    #1;
    g = '0;
    stalls = 0;
    if (rst) begin
      chk("q_ready_in_reset", 64'(tcdm.q_ready), 64'(0));
      reset_model();
    end else begin
      for (int b = 0; b < NB; b++) begin
        best = -1;
        bestd = NP;
        for (int k = 0; k < NP; k++) begin
          if (rv[k] && bank_of(ra[k]) == b) begin
            d = (k - ptr_m[b] + NP) % NP;
            if (d < bestd) begin bestd = d; best = k; end
          end
        end
        if (best >= 0) begin
          g[best] = 1'b1;
          ptr_m[b] = (best + 1) % NP;
        end
      end
      chk("q_ready", 64'(tcdm.q_ready), 64'(g));
      for (int k = 0; k < NP; k++) begin
        if (g[k] && !rw[k]) begin
          w = word_of(ra[k]);
          e.cyc = cyc + 1;
          e.known = mem_m.exists(w);
          e.data = e.known ? mem_m[w] : '0;
          expq[k].push_back(e);
        end
      end
      for (int k = 0; k < NP; k++) begin
        if (g[k] && rw[k]) begin
          w = word_of(ra[k]);
          word = mem_m.exists(w) ? mem_m[w] : '0;
          for (int j = 0; j < SW; j++) if (rs[k][j]) word[j*8 +: 8] = rdat[k][j*8 +: 8];
          mem_m[w] = word;
        end
      end
      for (int k = 0; k < NP; k++) begin
        if (rv[k] && !g[k]) stalls++;
        if (g[k]) rv[k] = 1'b0;
      end
      exp_cnt = exp_cnt + longint'(stalls);
      if (exp_cnt > 64'h0000_0000_FFFF_FFFF) exp_cnt = 64'h0000_0000_FFFF_FFFF;
    end
  endtask

  function automatic bit any_pending();
    for (int k = 0; k < NP; k++) if (rv[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int n = 0;
    while (any_pending()) begin
      step();
      n++;
      if (n > 64) begin
        nchk++; nerr++;
        $display("FAIL drain_timeout: actual=pending required=idle after %0d cycles", n);
        reset_model();
        break;
      end
    end
    idle(2);
  endtask

  // Monitor: compare every presented or expected response against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("conflict_cnt", 64'(conflict_cnt), exp_cnt);
        for (int k = 0; k < NP; k++) begin
          bit   en;
          exp_t e;
          en = (expq[k].size() > 0) && (expq[k][0].cyc <= cyc);
          if (tcdm.p_valid[k] || en) begin
            chk($sformatf("p_valid[%0d]", k), 64'(tcdm.p_valid[k]), 64'(en));
            if (en) begin
              e = expq[k].pop_front();
              if (e.known && tcdm.p_valid[k])
                chk($sformatf("p_data[%0d]", k), tcdm.p_data[k*DW +: DW], e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < NP; k++) begin
      rv[k] = 1'b0; ra[k] = 0; rw[k] = 1'b0; rdat[k] = '0; rs[k] = '0;
    end
    reset_model();

    // Reset, then enable monitor
    rst_req = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    rst_req = 1'b0;

    // Full write then read on another port
    req(0, 1'b1, 'h00040, 64'hDEADBEEF01234567, 8'hFF);
    step();
    req(3, 1'b0, 'h00040, '0, '0);
    step();
    idle(2);

    // Partial-strobe merge
    req(1, 1'b1, 'h00048, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    step();
    req(1, 1'b1, 'h00048, 64'h1111111122222222, 8'h0F);
    step();
    req(1, 1'b0, 'h00048, '0, '0);
    step();
    idle(2);

    // Three-way conflict on bank 5 right after reset
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    req(0, 1'b0, 'h028, '0, '0);
    req(1, 1'b0, 'h128, '0, '0);
    req(2, 1'b0, 'h228, '0, '0);
    drain();
    chk("conflict_after_bank5", 64'(conflict_cnt), 64'd3);

    // All ports hit distinct banks in one cycle
    for (int k = 0; k < NP; k++) req(k, 1'b0, k * 8, '0, '0);
    step();
    drain();

    // Reset lands on the edge after a read grant: response dropped, state cleared
    req(2, 1'b0, 'h028, '0, '0);
    step();
    #2;
    rst = 1'b1;
    reset_model();
    @(posedge clk);
    #1;
    chk("p_valid2_after_reset", 64'(tcdm.p_valid[2]), 64'd0);
    chk("conflict_after_reset", 64'(conflict_cnt), 64'd0);
    req(3, 1'b0, 'h128, '0, '0);
    req(0, 1'b0, 'h028, '0, '0);
    drain();

    // Upper address bit aliases
    req(4, 1'b1, 'h10040, 64'hA5A5A5A5A5A5A5A5, 8'hFF);
    step();
    req(5, 1'b0, 'h00040, '0, '0);
    step();
    idle(2);

    // Prefill a pool of rows 0..3 in every bank
    for (int r = 0; r < 4; r++) begin
      for (int h = 0; h < 2; h++) begin
        for (int k = 0; k < NP; k++)
          req(k, 1'b1, r * 256 + (h * 16 + k) * 8, {$urandom(), $urandom()}, 8'hFF);
        step();
      end
    end

    // Random traffic inside the prefilled pool, with aliasing and partial writes
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NP; k++) begin
        if (!rv[k] && $urandom_range(0, 1) == 1) begin
          int a;
          a = $urandom_range(0, 1) * 65536 + $urandom_range(0, 3) * 256
            + $urandom_range(0, NB - 1) * 8 + $urandom_range(0, 7);
          req(k, ($urandom_range(0, 2) == 0), a, {$urandom(), $urandom()}, SW'($urandom()));
        end
      end
      step();
    end
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
